// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential fetch and next-PC unit: BOOT -> FETCH (req/ack) -> EXEC, with
// next-PC selection from the decoder's PCOp, ALU zero flag and jr detect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instr,
    output logic [5:0]                 opcode,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    input  logic [1:0]                 PCOp,
    input  logic                       zero,
    input  logic                       isJR,
    input  logic [31:0]                jr_target,
    input  logic                       stall
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] branch_target;
    logic [31:0] branch_offset;

    // The address bus follows the PC directly, so it is stable for the whole FETCH.
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;
    assign opcode         = instr[31:26];

    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    always_comb begin
        next_pc = pc_plus4;
        if (isJR) begin
            next_pc = jr_target & ~32'h3;
        end else if (PCOp == 2'b11) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (PCOp == 2'b01 && zero) begin
            next_pc = branch_target;
        end else if (PCOp == 2'b10 && !zero) begin
            next_pc = branch_target;
        end
    end

    // req and valid are registered so reset removes them without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_PC & ~32'h3;
            instr         <= '0;
            imem.imem_req <= 1'b0;
            instr_valid   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state         <= FETCH;
                    imem.imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr         <= imem.imem_rdata;
                        state         <= EXEC;
                        imem.imem_req <= 1'b0;
                        instr_valid   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc            <= next_pc;
                        state         <= FETCH;
                        imem.imem_req <= 1'b1;
                        instr_valid   <= 1'b0;
                    end
                end
                default: begin
                    state         <= BOOT;
                    imem.imem_req <= 1'b0;
                    instr_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-step bench for instruction_fetch with RESET_PC = 0x100.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  PCOp;
    logic        zero;
    logic        isJR;
    logic [31:0] jr_target;
    logic        stall;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_instr;

    localparam logic [31:0] W_NOP  = 32'h0000_0000;
    localparam logic [31:0] W_JR   = 32'h03E0_0008;
    localparam logic [31:0] W_BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] W_BNE  = 32'h1400_0004;
    localparam logic [31:0] W_J80  = 32'h0800_0080;
    localparam logic [31:0] W_J40  = 32'h0800_0040;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .PCOp        (PCOp),
        .zero        (zero),
        .isJR        (isJR),
        .jr_target   (jr_target),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after an edge with the DUT in FETCH; memory acks after 'waits' cycles.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
        chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("fetch_addr", bus.imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, addr);
            chk("wait_instr", instr, exp_instr);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hFFFF_FFFF;
        exp_instr = word;
        chk("exec_instr", instr, word);
        chk("exec_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_req", {31'd0, bus.imem_req}, 32'd0);
    endtask

    task automatic do_exec(input logic [1:0] op, input logic z, input logic jr,
                           input logic [31:0] jt, input logic [31:0] exp_pc);
        PCOp = op; zero = z; isJR = jr; jr_target = jt; stall = 1'b0;
        @(posedge clk); #1;
        PCOp = 2'b00; zero = 1'b0; isJR = 1'b0; jr_target = '0;
        chk("next_pc", pc, exp_pc);
        chk("next_addr", bus.imem_addr, exp_pc);
        chk("next_pc4", pc_plus4, exp_pc + 32'd4);
        chk("next_req", {31'd0, bus.imem_req}, 32'd1);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        PCOp = 2'b00; zero = 1'b0; isJR = 1'b0; jr_target = '0; stall = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        exp_instr = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_addr", bus.imem_addr, 32'h100);
        chk("rst_pc4", pc_plus4, 32'h104);

        rst_n = 1'b1;
        #2;
        chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk); #1;

        // 0-wait sequential stream
        do_fetch(32'h100, W_NOP, 0);
        do_exec(2'b00, 1'b0, 1'b0, '0, 32'h104);
        do_fetch(32'h104, W_NOP, 0);
        do_exec(2'b00, 1'b1, 1'b0, '0, 32'h108);

        // three wait states, then jr to 0x200
        do_fetch(32'h108, W_JR, 3);
        do_exec(2'b00, 1'b0, 1'b1, 32'h0000_0200, 32'h200);

        // beq taken backwards, j back, beq not taken
        do_fetch(32'h200, W_BEQ, 0);
        do_exec(2'b01, 1'b1, 1'b0, '0, 32'h1FC);
        do_fetch(32'h1FC, W_J80, 0);
        do_exec(2'b11, 1'b0, 1'b0, '0, 32'h200);
        do_fetch(32'h200, W_BEQ, 1);
        do_exec(2'b01, 1'b0, 1'b0, '0, 32'h204);
        do_fetch(32'h204, W_JR, 0);
        do_exec(2'b00, 1'b0, 1'b1, 32'h0000_0200, 32'h200);

        // bne taken forwards
        do_fetch(32'h200, W_BNE, 0);
        do_exec(2'b10, 1'b0, 1'b0, '0, 32'h214);

        // jumps in the 0x4xxx_xxxx region
        do_fetch(32'h214, W_JR, 0);
        do_exec(2'b00, 1'b0, 1'b1, 32'h4000_0010, 32'h4000_0010);
        do_fetch(32'h4000_0010, W_J40, 0);
        do_exec(2'b11, 1'b0, 1'b0, '0, 32'h4000_0100);
        do_fetch(32'h4000_0100, W_JR, 0);

        // stall five cycles with junk on the next-PC inputs
        stall = 1'b1;
        PCOp = 2'b11; isJR = 1'b1; jr_target = 32'h1234_5678; zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_pc", pc, 32'h4000_0100);
            chk("stall_instr", instr, W_JR);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end

        // jr wins over simultaneous PCOp=11; low bits dropped
        do_exec(2'b11, 1'b0, 1'b1, 32'h0000_0ABF, 32'h0000_0ABC);

        // wrap from the top of the address space
        do_fetch(32'h0000_0ABC, W_JR, 0);
        do_exec(2'b00, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0000_0000);
        do_fetch(32'hFFFF_FFFC, W_NOP, 0);
        do_exec(2'b00, 1'b0, 1'b0, '0, 32'h0000_0000);

        // reset during a pending fetch, then a late ack
        @(posedge clk); #2;
        chk("pend_req", {31'd0, bus.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_pc", pc, 32'h100);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        chk("late_instr", instr, 32'd0);
        chk("late_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_req", {31'd0, bus.imem_req}, 32'd0);
        rst_n = 1'b1;
        #2;
        chk("reboot_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk); #1;
        exp_instr = '0;
        do_fetch(32'h100, 32'h2001_0005, 0);

        // reset during EXEC drops valid immediately, no PC update
        #2;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("exec_rst_pc", pc, 32'h100);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
